// File: rtl/saber_centroid_if.sv
// Pixel stream in, per-frame saber-tip centroid out.
// The master drives pixels; the slave is the centroid block.
interface saber_centroid_if;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic        valid_in;
    logic        tabulate_in;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        found_out;

    modport master (
        output x_in, y_in, valid_in, tabulate_in,
        input  x_out, y_out, valid_out, found_out
    );
    modport slave (
        input  x_in, y_in, valid_in, tabulate_in,
        output x_out, y_out, valid_out, found_out
    );
endinterface

// File: rtl/saber_centroid.sv
// Per-frame saber centroid: accumulate matching pixels, divide bit-serially,
// optionally smooth across frames, then pulse the result to the trace stage.

module saber_centroid_div #(
    parameter int DVD_W = 30,
    parameter int CNT_W = 20,
    parameter int OUT_W = 11
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [DVD_W-1:0] dvd_i,
    input  logic [CNT_W-1:0] dvs_i,
    output logic [OUT_W-1:0] quo_o
);
    // Dividend shifts out of the top of quo_q while quotient bits shift in below.
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W:0]   rem_sh, diff;

    always_comb begin
        rem_sh = {rem_q, quo_q[DVD_W-1]};
        diff   = rem_sh - {1'b0, dvs_i};
        rem_d  = diff[CNT_W] ? rem_sh[CNT_W-1:0] : diff[CNT_W-1:0];
        quo_d  = {quo_q[DVD_W-2:0], ~diff[CNT_W]};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            quo_q <= '0;
            rem_q <= '0;
        end else if (load_i) begin
            quo_q <= dvd_i;
            rem_q <= '0;
        end else if (step_i) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
        end
    end

    assign quo_o = quo_q[OUT_W-1:0];
endmodule

module saber_centroid #(
    parameter int MIN_PIXELS   = 16,
    parameter int SMOOTH_SHIFT = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    saber_centroid_if.slave   bus
);
    localparam int DIV_CYCLES = 30;

    typedef enum logic [1:0] {ACCUM, DIVIDE, SMOOTH, OUTPUT} state_e;
    state_e state_q, state_d;
    logic [4:0]  iter_q, iter_d;
    logic        take, step, smooth_en, valid_d;

    logic [19:0] cnt_q, cnt_d, cnt_nx, snap_cnt_q;
    logic [29:0] sx_q, sx_d, sx_nx;
    logic [28:0] sy_q, sy_d, sy_nx;

    logic [10:0] meas_x, pos_x_q, pos_x_d;
    logic [9:0]  meas_y, pos_y_q, pos_y_d;
    logic        found_q, found_d, found_meas;
    logic signed [11:0] dx, dy, dx_sh, dy_sh, nx_x, nx_y;
    logic        unused_hi;

    // The closing pixel of a frame lands in the snapshot, not the next frame.
    always_comb begin
        cnt_nx = cnt_q + {19'd0, bus.valid_in};
        sx_nx  = sx_q + (bus.valid_in ? 30'(bus.x_in) : 30'd0);
        sy_nx  = sy_q + (bus.valid_in ? 29'(bus.y_in) : 29'd0);
        cnt_d  = take ? '0 : cnt_nx;
        sx_d   = take ? '0 : sx_nx;
        sy_d   = take ? '0 : sy_nx;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q      <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            snap_cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sx_q  <= sx_d;
            sy_q  <= sy_d;
            if (take) snap_cnt_q <= cnt_nx;
        end
    end

    saber_centroid_div #(.DVD_W(30), .CNT_W(20), .OUT_W(11)) u_div_x (
        .clk_in(clk_in), .rst_in(rst_in), .load_i(take), .step_i(step),
        .dvd_i(sx_nx), .dvs_i(snap_cnt_q), .quo_o(meas_x)
    );
    saber_centroid_div #(.DVD_W(30), .CNT_W(20), .OUT_W(10)) u_div_y (
        .clk_in(clk_in), .rst_in(rst_in), .load_i(take), .step_i(step),
        .dvd_i({1'b0, sy_nx}), .dvs_i(snap_cnt_q), .quo_o(meas_y)
    );

    always_comb begin
        state_d   = state_q;
        iter_d    = '0;
        take      = 1'b0;
        step      = 1'b0;
        smooth_en = 1'b0;
        valid_d   = 1'b0;
        case (state_q)
            ACCUM: if (bus.tabulate_in) begin
                take    = 1'b1;
                state_d = DIVIDE;
            end
            DIVIDE: begin
                step   = 1'b1;
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'(DIV_CYCLES - 1)) begin
                    iter_d  = '0;
                    state_d = SMOOTH;
                end
            end
            SMOOTH: begin
                smooth_en = 1'b1;
                state_d   = OUTPUT;
            end
            OUTPUT: begin
                valid_d = 1'b1;
                state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ACCUM;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // Signed 12b step toward the new measurement; >>> floors toward -inf.
    always_comb begin
        found_meas = snap_cnt_q >= 20'(MIN_PIXELS);
        dx         = {1'b0, meas_x} - {1'b0, pos_x_q};
        dy         = {2'b0, meas_y} - {2'b0, pos_y_q};
        dx_sh      = dx >>> SMOOTH_SHIFT;
        dy_sh      = dy >>> SMOOTH_SHIFT;
        nx_x       = {1'b0, pos_x_q} + dx_sh;
        nx_y       = {2'b0, pos_y_q} + dy_sh;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        found_d    = found_q;
        if (smooth_en) begin
            if (found_meas) begin
                found_d = 1'b1;
                pos_x_d = found_q ? nx_x[10:0] : meas_x;
                pos_y_d = found_q ? nx_y[9:0]  : meas_y;
            end else begin
                found_d = 1'b0;
            end
        end
    end

    assign unused_hi = ^{nx_x[11], nx_y[11:10]};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
            found_q <= 1'b0;
        end else begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            found_q <= found_d;
        end
    end

    assign bus.x_out     = pos_x_q;
    assign bus.y_out     = pos_y_q;
    assign bus.found_out = found_q;
    assign bus.valid_out = valid_d;
endmodule
